// File: rtl/pcle_state_reg_pkg.sv
// Shared definitions for the pcle_state_reg counter block.
//   - pcle_mode_e : per-cycle operating mode (HOLD / COUNT / LOAD)
//   - DEF_WIDTH   : default counter width
//   - DEF_WRAPW   : default width of the saturating wrap counter
//   - mode_sel()  : resolves ld/en/inh into a mode (load has priority)
package pcle_state_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'd0,
    MODE_COUNT = 2'd1,
    MODE_LOAD  = 2'd2
  } pcle_mode_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_WRAPW = 4;

  // Load beats everything; inhibit only blocks counting.
  function automatic pcle_mode_e mode_sel(input logic ld, input logic en,
                                          input logic inh);
    if (ld)
      return MODE_LOAD;
    else if (en && !inh)
      return MODE_COUNT;
    else
      return MODE_HOLD;
  endfunction

endpackage

// File: rtl/pcle_state_reg_next.sv
// pcle_next: combinational next-state logic for the counter.
// Ports:
//   q      in  WIDTH  current count
//   d      in  WIDTH  parallel load data
//   ld     in  1      load request
//   en     in  1      count enable
//   inh    in  1      count inhibit
//   next_q out WIDTH  value q takes at the next edge
//   co     out 1      carry out (counting from all-ones)
//   mode   out        resolved mode for this cycle
module pcle_next
  import pcle_state_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             ld,
  input  logic             en,
  input  logic             inh,
  output logic [WIDTH-1:0] next_q,
  output logic             co,
  output pcle_mode_e       mode
);

  always_comb begin
    mode   = mode_sel(ld, en, inh);
    next_q = q;
    co     = 1'b0;
    case (mode)
      MODE_LOAD:  next_q = d;
      MODE_COUNT: begin
        next_q = q + WIDTH'(1);
        // Carry only comes from counting; loading all-ones is not a wrap.
        co     = &q;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pcle_state_reg.sv
// pcle_state_reg: loadable up-counter with carry, terminal-count pulse,
// compare-match pulse, sticky overflow flag and saturating wrap counter.
// Ports:
//   clk   in  1      clock, rising edge
//   rst   in  1      synchronous active-high reset
//   ld    in  1      parallel load (highest priority)
//   en    in  1      count enable
//   inh   in  1      count inhibit (does not block load)
//   d     in  WIDTH  load data
//   cmp   in  WIDTH  compare value for match
//   ack   in  1      clears ovf and wraps
//   q     out WIDTH  registered count
//   co    out 1      combinational carry out
//   tc    out 1      one-cycle pulse after a wrap edge
//   match out 1      one-cycle pulse after q moves onto cmp
//   ovf   out 1      sticky overflow
//   wraps out WRAPW  saturating wrap count
module pcle_state_reg
  import pcle_state_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int WRAPW = DEF_WRAPW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             en,
  input  logic             inh,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] cmp,
  input  logic             ack,
  output logic [WIDTH-1:0] q,
  output logic             co,
  output logic             tc,
  output logic             match,
  output logic             ovf,
  output logic [WRAPW-1:0] wraps
);

  localparam logic [WRAPW-1:0] WRAP_MAX = '1;

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             match_q, match_d;
  logic             ovf_q, ovf_d;
  logic [WRAPW-1:0] wraps_q, wraps_d;

  logic [WIDTH-1:0] next_q;
  logic             co_raw;
  logic             wrap;
  pcle_mode_e       mode;

  pcle_next #(.WIDTH(WIDTH)) u_next (
    .q      (q_q),
    .d      (d),
    .ld     (ld),
    .en     (en),
    .inh    (inh),
    .next_q (next_q),
    .co     (co_raw),
    .mode   (mode)
  );

  // Reset suppresses the carry so a pending wrap is discarded.
  assign wrap = co_raw & ~rst;

  always_comb begin
    q_d     = next_q;
    tc_d    = wrap;
    // In COUNT the value always moves and LOAD always qualifies, so any
    // non-HOLD mode landing on cmp fires the pulse.
    match_d = (mode != MODE_HOLD) && (next_q == cmp);

    ovf_d   = ovf_q;
    if (wrap)
      ovf_d = 1'b1;
    else if (ack)
      ovf_d = 1'b0;

    wraps_d = wraps_q;
    if (ack)
      wraps_d = wrap ? WRAPW'(1) : '0;
    else if (wrap && wraps_q != WRAP_MAX)
      wraps_d = wraps_q + WRAPW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q     <= '0;
      tc_q    <= 1'b0;
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
      wraps_q <= '0;
    end else begin
      q_q     <= q_d;
      tc_q    <= tc_d;
      match_q <= match_d;
      ovf_q   <= ovf_d;
      wraps_q <= wraps_d;
    end
  end

  assign q     = q_q;
  assign co    = wrap;
  assign tc    = tc_q;
  assign match = match_q;
  assign ovf   = ovf_q;
  assign wraps = wraps_q;

endmodule
